matrix_row_feeder: RTL
======================

// Module: matrix_row_feeder
// PURPOSE
//  Responder side of the matrix-by-vector row-fetch protocol. When the matrix controller pulses its fetch
//  request, this block reads the next group of rows from memory: one A row segment, its matching vector
//  segment and its multiple count for each row-by-vector module. It packs them onto the wide A_rows,
//  vector_rows and no_of_multiples buses and raises a per-slot you_can_read flag as each slot loads.
// PARAMETERS
//  element_width                 32  bits per matrix/vector element
//  no_of_row_by_vector_modules   4   M, rows served per group (one per row-by-vector module)
//  NI                            8   elements per row segment
//  ADDR_W                        16  memory address width
// PORTS
//  clk                      in   1         clock; all logic on posedge
//  reset                    in   1         synchronous, active-high
//  start                    in   1         level; same start the matrix controller sees; low = abort to IDLE
//  req                      in   1         fetch request (controller memories_pre_preprocess); 1-cycle pulse
//  total_rows               in   32        real matrix rows
//  total_with_additional_A  in   32        rows incl. padding; multiple of M
//  a_base                   in   ADDR_W    A memory base address
//  v_base                   in   ADDR_W    vector memory base address
//  mem_rd_en                out  1         read strobe shared by A, vector and length memories
//  mem_addr                 out  ADDR_W    row offset r (A addr = a_base+r, V addr = v_base+r, driven as pair)
//  a_rdata                  in   NI*element_width  A segment, valid 1 cycle after mem_rd_en
//  v_rdata                  in   NI*element_width  vector segment, same timing
//  len_rdata                in   32        multiple count for row r, same timing
//  a_addr                   out  ADDR_W    a_base+r
//  v_addr                   out  ADDR_W    v_base+r
//  A_rows                   out  M*NI*element_width  slot k at [(M-k)*NI*element_width-1 -: NI*element_width]
//  vector_rows              out  M*NI*element_width  same slot packing
//  no_of_multiples          out  M*32      slot k at [(M-k)*32-1 -: 32]
//  you_can_read             out  M         slot k loaded -> bit [M-1-k]
//  feed_done                out  1         all groups served; held until start low
//  overrun                  out  1         sticky: req received while busy or after done
// BEHAVIOUR
//  - Reset (or start low): state IDLE; every output 0; row pointer r=0; group count g=0.
//  - FSM: IDLE -(start)-> WAIT; WAIT -(req)-> ISSUE; ISSUE (M cycles) -> DRAIN (1 cycle) -> WAIT;
//    WAIT -(g==total_with_additional_A/M)-> DONE; DONE holds until start low.
//  - On the edge that samples req in WAIT: you_can_read<=0, all slots keep old data, g<=g+1.
//  - ISSUE: mem_rd_en=1 for exactly M consecutive cycles, slot k in the k-th cycle, mem_addr=r+k; r+=M at end.
//  - Read latency 1: slot k registers (A, vector, length) and you_can_read[M-1-k] update together
//    at the edge ending the data cycle. With req sampled at edge 0, slot k loads at edge k+2;
//    all M bits are high after edge M+1.
//  - Outputs are registered and held stable between loads; the consumer may read at any time bits are set.
//  - req in ISSUE/DRAIN or DONE: ignored, overrun<=1 (cleared only by reset or start low).
//  - req and start falling in the same cycle: start wins; go to IDLE, no read issued.
//  - total_with_additional_A==0: WAIT moves straight to DONE; feed_done=1 the cycle after start rises.
//  - Address arithmetic wraps modulo 2^ADDR_W; no error on wrap.
// CONFIGURATION
//  FEEDER_ZERO_PAD_EN defined: slots with row r >= total_rows issue no read. The mem_rd_en cycle stays low,
//    but slot timing is unchanged. The slot loads A=0, vector=0, length=1 and the you_can_read bit is still set.
//  Not defined: padding rows are read from memory like real rows; returned data is used unchanged.
// TESTING
//  1 reset mid-ISSUE (M=4) -> next cycle mem_rd_en=0, you_can_read=0, all buses 0, state IDLE.
//  2 total_with_additional_A=8, req at edge 0 -> mem_addr 0,1,2,3 on cycles 1-4; you_can_read=4'b1111 after edge 5.
//  3 second req after group 1 -> addrs 4..7; feed_done=1 after WAIT sees g==2; third req -> overrun=1.
//  4 req again 2 cycles after first req -> ignored, overrun=1, addresses still 0..3 only.
//  5 total_rows=6, padded total 8, FEEDER_ZERO_PAD_EN -> group 2 reads only r=4,5; slots 2,3 A=0, length=1.
//  6 start low during DRAIN -> IDLE next cycle; start high + req -> fetch restarts at r=0, overrun=0.

Source files
------------

// File: rtl/matrix_row_feeder.sv
// Row-fetch responder: reads one A segment, vector segment and multiple count per row-by-vector slot and packs them.
// Optional feature macro FEEDER_ZERO_PAD_EN: padding rows (r >= total_rows) skip the memory read and load A=0, vector=0, length=1.
module matrix_row_feeder #(
  parameter int element_width               = 32,
  parameter int no_of_row_by_vector_modules = 4,
  parameter int NI                          = 8,
  parameter int ADDR_W                      = 16
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic                                                 req,
  input  logic [31:0]                                          total_rows,
  input  logic [31:0]                                          total_with_additional_A,
  input  logic [ADDR_W-1:0]                                    a_base,
  input  logic [ADDR_W-1:0]                                    v_base,
  output logic                                                 mem_rd_en,
  output logic [ADDR_W-1:0]                                    mem_addr,
  input  logic [NI*element_width-1:0]                          a_rdata,
  input  logic [NI*element_width-1:0]                          v_rdata,
  input  logic [31:0]                                          len_rdata,
  output logic [ADDR_W-1:0]                                    a_addr,
  output logic [ADDR_W-1:0]                                    v_addr,
  output logic [no_of_row_by_vector_modules*NI*element_width-1:0] A_rows,
  output logic [no_of_row_by_vector_modules*NI*element_width-1:0] vector_rows,
  output logic [no_of_row_by_vector_modules*32-1:0]            no_of_multiples,
  output logic [no_of_row_by_vector_modules-1:0]               you_can_read,
  output logic                                                 feed_done,
  output logic                                                 overrun
);

  localparam int M     = no_of_row_by_vector_modules;
  localparam int SEG_W = NI * element_width;
  localparam int SW    = (M > 1) ? $clog2(M) : 1;

`ifdef FEEDER_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [SW-1:0]       cnt_q;
  logic [31:0]         row_q;
  logic [31:0]         grp_q;
  logic                mem_rd_en_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [ADDR_W-1:0]   a_addr_q;
  logic [ADDR_W-1:0]   v_addr_q;
  logic [M*SEG_W-1:0]  a_rows_q;
  logic [M*SEG_W-1:0]  vec_rows_q;
  logic [M*32-1:0]     mult_q;
  logic [M-1:0]        ycr_q;
  logic                feed_done_q;
  logic                overrun_q;
  logic                dat_valid_q;
  logic [SW-1:0]       dat_slot_q;
  logic                dat_pad_q;

  logic [31:0]         issue_row_d;
  logic [31:0]         groups_total_d;
  logic                issue_pad_d;

  // Row offset of the slot whose read goes out in the next cycle.
  always_comb begin
    issue_row_d    = row_q;
    groups_total_d = total_with_additional_A / 32'(M);
    if (state_q == S_ISSUE) begin
      issue_row_d = row_q + 32'(cnt_q) + 32'd1;
    end else begin
      issue_row_d = row_q;
    end
    issue_pad_d = PAD_EN && (issue_row_d >= total_rows);
  end

  // Sequencer, read pipeline and slot registers; start low behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || !start) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_q       <= 32'd0;
      grp_q       <= 32'd0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      a_addr_q    <= '0;
      v_addr_q    <= '0;
      a_rows_q    <= '0;
      vec_rows_q  <= '0;
      mult_q      <= '0;
      ycr_q       <= '0;
      feed_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      dat_valid_q <= 1'b0;
      dat_slot_q  <= '0;
      dat_pad_q   <= 1'b0;
    end else begin
      // A suppressed (padding) read shows up as an ISSUE cycle with the strobe low.
      dat_valid_q <= (state_q == S_ISSUE);
      dat_slot_q  <= cnt_q;
      dat_pad_q   <= (state_q == S_ISSUE) && !mem_rd_en_q;

      if (dat_valid_q) begin
        for (int k = 0; k < M; k++) begin
          if (dat_slot_q == SW'(k)) begin
            a_rows_q[(M-k)*SEG_W-1 -: SEG_W] <= dat_pad_q ? {SEG_W{1'b0}} : a_rdata;
            vec_rows_q[(M-k)*SEG_W-1 -: SEG_W] <= dat_pad_q ? {SEG_W{1'b0}} : v_rdata;
            mult_q[(M-k)*32-1 -: 32] <= dat_pad_q ? 32'd1 : len_rdata;
            ycr_q[M-1-k] <= 1'b1;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (grp_q == groups_total_d) begin
            state_q     <= S_DONE;
            feed_done_q <= 1'b1;
            if (req) begin
              overrun_q <= 1'b1;
            end
          end else if (req) begin
            state_q     <= S_ISSUE;
            ycr_q       <= '0;
            grp_q       <= grp_q + 32'd1;
            cnt_q       <= '0;
            mem_rd_en_q <= !issue_pad_d;
            mem_addr_q  <= issue_row_d[ADDR_W-1:0];
            a_addr_q    <= a_base + issue_row_d[ADDR_W-1:0];
            v_addr_q    <= v_base + issue_row_d[ADDR_W-1:0];
          end
        end
        S_ISSUE: begin
          if (req) begin
            overrun_q <= 1'b1;
          end
          if (cnt_q == SW'(M-1)) begin
            state_q     <= S_DRAIN;
            mem_rd_en_q <= 1'b0;
            row_q       <= row_q + 32'(M);
          end else begin
            cnt_q       <= cnt_q + SW'(1);
            mem_rd_en_q <= !issue_pad_d;
            mem_addr_q  <= issue_row_d[ADDR_W-1:0];
            a_addr_q    <= a_base + issue_row_d[ADDR_W-1:0];
            v_addr_q    <= v_base + issue_row_d[ADDR_W-1:0];
          end
        end
        S_DRAIN: begin
          if (req) begin
            overrun_q <= 1'b1;
          end
          state_q <= S_WAIT;
        end
        S_DONE: begin
          if (req) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en       = mem_rd_en_q;
  assign mem_addr        = mem_addr_q;
  assign a_addr          = a_addr_q;
  assign v_addr          = v_addr_q;
  assign A_rows          = a_rows_q;
  assign vector_rows     = vec_rows_q;
  assign no_of_multiples = mult_q;
  assign you_can_read    = ycr_q;
  assign feed_done       = feed_done_q;
  assign overrun         = overrun_q;

endmodule
